// File: rtl/mpi_link_arbiter.sv
// Round-robin arbiter sharing one MPI transport slot among NUM_CH channels,
// with per-channel remote credit tracking and a finalize/drain sequence.
module mpi_link_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 64,
    parameter int CREDITS = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_ready_o,
    output logic                     tx_valid_o,
    output logic [CH_W-1:0]          tx_chan_o,
    output logic [DATA_W-1:0]        tx_data_o,
    input  logic                     tx_ack_i,
    input  logic [NUM_CH-1:0]        rx_yummy_i,
    input  logic                     finalize_i,
    output logic [NUM_CH*CNT_W-1:0]  credit_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [1:0]               state_o
);

    // Handshakes: a channel flit moves when ch_valid_i[c] & ch_ready_o[c] in the
    // same cycle; the tx flit is held stable while tx_valid_o=1 until tx_ack_i.
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    credit_q [NUM_CH];
    logic [CNT_W-1:0]    credit_d [NUM_CH];
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     tx_chan_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                err_q;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant;
    logic [CH_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_any;
    logic                overflow;
    logic                all_full;

    // Arbitration: first eligible channel at or after rr, wrapping.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx        = '0;
        eligible   = '0;
        grant      = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        grant_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = ch_valid_i[c] && (credit_q[c] != '0);
        end
        if (state_q == IDLE && !finalize_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = CH_W'((int'(rr_q) + k) % NUM_CH);
                if (!grant_any && eligible[idx]) begin
                    grant_any   = 1'b1;
                    grant_idx   = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) grant_data = ch_data_i[c*DATA_W +: DATA_W];
        end
    end

    // A yummy into a full counter is dropped and flagged rather than wrapping.
    always_comb begin
        overflow = 1'b0;
        all_full = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            credit_d[c] = credit_q[c];
            if (rx_yummy_i[c] && !grant[c]) begin
                if (credit_q[c] == FULL) overflow = 1'b1;
                else                     credit_d[c] = credit_q[c] + CNT_ONE;
            end else if (!rx_yummy_i[c] && grant[c]) begin
                credit_d[c] = credit_q[c] - CNT_ONE;
            end
            if (credit_d[c] != FULL) all_full = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (finalize_i)     state_d = DRAIN;
                   else if (grant_any) state_d = SEND;
            SEND:  if (tx_ack_i)       state_d = finalize_i ? DRAIN : IDLE;
            DRAIN: if (all_full)       state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_ready_o = grant;
        tx_valid_o = (state_q == SEND);
        done_o     = (state_q == DONE);
        state_o    = state_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) credit_q[c] <= FULL;
            rr_q      <= '0;
            tx_chan_q <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) credit_q[c] <= credit_d[c];
            err_q <= err_q | overflow;
            if (grant_any) begin
                tx_chan_q <= grant_idx;
                tx_data_q <= grant_data;
                rr_q      <= (grant_idx == CH_LAST) ? '0 : grant_idx + CH_ONE;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) credit_o[c*CNT_W +: CNT_W] = credit_q[c];
    end

    assign tx_chan_o = tx_chan_q;
    assign tx_data_o = tx_data_q;
    assign err_o     = err_q;

endmodule
